axis_pipe_slice_chain: RTL and testbench

- Parametrised AXI4-Stream register pipeline for the image VIP test path.
- Successor to the fixed always-ready delay line. Each stage is a full-throughput register slice with true valid/ready backpressure.
- Adds width adaptation between source and sink byte counts.
- Adds optional beat/frame statistics for scoreboard cross-checks.
- Sits between the VIP source driver and the sink monitor, or inside a DUT-under-test wrapper.

---
 rtl/axis_pipe_pkg.sv | 20 ++
 rtl/axis_reg_slice.sv | 95 +++++++++
 rtl/axis_pipe_slice_chain.sv | 121 ++++++++++++
 tb/tb_axis_pipe_slice_chain.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pipe_pkg.sv
// Shared types for the AXI4-Stream register-slice chain: slice occupancy states,
// the stage-count ceiling and a default-width beat record.
package axis_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    localparam int MAX_PIPELINE_STAGES = 8;

    localparam int BEAT_DATA_BITS = 32;

    typedef struct packed {
        logic [BEAT_DATA_BITS-1:0] data;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One full-throughput AXI4-Stream register slice: a main register plus a skid
// register. Input ready is a flop, so there is no combinational path from out_ready_i.
//
// state | meaning
// EMPTY | no beat held, out_valid_o low
// HALF  | main holds a beat, skid free, in_ready_o high
// FULL  | main and skid both hold beats, in_ready_o low
module axis_reg_slice
    import axis_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } slice_beat_t;

    slice_state_e state_q, state_d;
    logic         ready_q, ready_d;
    slice_beat_t  main_q, main_d;
    slice_beat_t  skid_q, skid_d;
    slice_beat_t  in_beat;
    logic         in_fire;
    logic         out_fire;

    assign in_beat  = '{data: in_data_i, last: in_last_i};
    assign in_fire  = in_valid_i & ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = HALF;
                    main_d  = in_beat;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    main_d = in_beat;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_beat;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = HALF;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Payload registers carry no reset; they are qualified by state_q.
    always_ff @(posedge clk_i) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q.data;
    assign out_last_o  = main_q.last;

endmodule

// File: rtl/axis_pipe_slice_chain.sv
// AXI4-Stream pipeline of PIPELINE_STAGES skid slices with input width adaptation.
// Defining AXIS_PIPE_STATS_EN adds beat_cnt_o / frame_cnt_o output-side statistics.
`ifndef AXIS_IMAGE_VIP_SOURCE_BYTES
`define AXIS_IMAGE_VIP_SOURCE_BYTES 4
`endif
`ifndef AXIS_IMAGE_VIP_SINK_BYTES
`define AXIS_IMAGE_VIP_SINK_BYTES 4
`endif

module axis_pipe_slice_chain
    import axis_pipe_pkg::*;
#(
    parameter int INPUT_BYTES     = `AXIS_IMAGE_VIP_SOURCE_BYTES,
    parameter int OUTPUT_BYTES    = `AXIS_IMAGE_VIP_SINK_BYTES,
    parameter int INPUT_BITS      = INPUT_BYTES * 8,
    parameter int OUTPUT_BITS     = OUTPUT_BYTES * 8,
    parameter int PIPELINE_STAGES = 2,
    parameter int CNT_BITS        = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [INPUT_BITS-1:0]  axis_s_data_i,
    input  logic                   axis_s_valid_i,
    output logic                   axis_s_ready_o,
    input  logic                   axis_s_last_i,
    output logic [OUTPUT_BITS-1:0] axis_m_data_o,
    output logic                   axis_m_valid_o,
    input  logic                   axis_m_ready_i,
    output logic                   axis_m_last_o
`ifdef AXIS_PIPE_STATS_EN
    ,
    output logic [CNT_BITS-1:0]    beat_cnt_o,
    output logic [CNT_BITS-1:0]    frame_cnt_o
`endif
);

    if (PIPELINE_STAGES < 1 || PIPELINE_STAGES > MAX_PIPELINE_STAGES) begin : g_bad_stages
        $fatal(1, "PIPELINE_STAGES=%0d outside 1..%0d", PIPELINE_STAGES, MAX_PIPELINE_STAGES);
    end
    if (CNT_BITS < 1) begin : g_bad_cnt_bits
        $fatal(1, "CNT_BITS=%0d must be at least 1", CNT_BITS);
    end

    logic [OUTPUT_BITS-1:0] adapt_data;

    // Adaptation happens once at the chain input so every stage is OUTPUT_BITS wide.
    if (OUTPUT_BITS < INPUT_BITS) begin : g_trunc
        logic unused_hi_bits;
        assign adapt_data     = axis_s_data_i[OUTPUT_BITS-1:0];
        assign unused_hi_bits = ^axis_s_data_i[INPUT_BITS-1:OUTPUT_BITS];
    end else if (OUTPUT_BITS > INPUT_BITS) begin : g_zext
        assign adapt_data = {{(OUTPUT_BITS-INPUT_BITS){1'b0}}, axis_s_data_i};
    end else begin : g_pass
        assign adapt_data = axis_s_data_i;
    end

    logic [OUTPUT_BITS-1:0] st_data  [PIPELINE_STAGES+1];
    logic                   st_valid [PIPELINE_STAGES+1];
    logic                   st_last  [PIPELINE_STAGES+1];
    logic                   st_ready [PIPELINE_STAGES+1];

    assign st_data[0]               = adapt_data;
    assign st_valid[0]              = axis_s_valid_i;
    assign st_last[0]               = axis_s_last_i;
    assign axis_s_ready_o           = st_ready[0];
    assign st_ready[PIPELINE_STAGES] = axis_m_ready_i;

    for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : g_stage
        axis_reg_slice #(
            .WIDTH (OUTPUT_BITS)
        ) u_slice (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .in_data_i   (st_data[k]),
            .in_valid_i  (st_valid[k]),
            .in_last_i   (st_last[k]),
            .in_ready_o  (st_ready[k]),
            .out_data_o  (st_data[k+1]),
            .out_valid_o (st_valid[k+1]),
            .out_last_o  (st_last[k+1]),
            .out_ready_i (st_ready[k+1])
        );
    end

    assign axis_m_data_o  = st_data[PIPELINE_STAGES];
    assign axis_m_valid_o = st_valid[PIPELINE_STAGES];
    assign axis_m_last_o  = st_last[PIPELINE_STAGES];

`ifdef AXIS_PIPE_STATS_EN
    logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic                m_fire;

    assign m_fire = axis_m_valid_o & axis_m_ready_i;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (m_fire) begin
            beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
            if (axis_m_last_o) begin
                frame_cnt_d = frame_cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign beat_cnt_o  = beat_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pipe_slice_chain.sv
// Directed bench for axis_pipe_slice_chain: reset, streaming, backpressure,
// random handshakes, width adaptation and reset with beats in flight.
module tb_axis_pipe_slice_chain;

    logic        clk_i = 1'b0;
    logic        rstn_i;

    logic [31:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [31:0] m_data;
    logic        m_valid, m_ready, m_last;

    logic [31:0] w42_s_data;
    logic        w42_s_valid, w42_s_last, w42_s_ready;
    logic [15:0] w42_m_data;
    logic        w42_m_valid, w42_m_last;

    logic [15:0] w24_s_data;
    logic        w24_s_valid, w24_s_last, w24_s_ready;
    logic [31:0] w24_m_data;
    logic        w24_m_valid, w24_m_last;

    logic        w_m_ready = 1'b1;

`ifdef AXIS_PIPE_STATS_EN
    logic [31:0] beat_cnt, frame_cnt;
    logic [31:0] unused_w42_beat, unused_w42_frame, unused_w24_beat, unused_w24_frame;
`endif

    always #5 clk_i = ~clk_i;

    axis_pipe_slice_chain #(
        .INPUT_BYTES(4), .OUTPUT_BYTES(4), .PIPELINE_STAGES(2), .CNT_BITS(32)
    ) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready),
        .axis_s_last_i(s_last),
        .axis_m_data_o(m_data), .axis_m_valid_o(m_valid), .axis_m_ready_i(m_ready),
        .axis_m_last_o(m_last)
`ifdef AXIS_PIPE_STATS_EN
        , .beat_cnt_o(beat_cnt), .frame_cnt_o(frame_cnt)
`endif
    );

    axis_pipe_slice_chain #(
        .INPUT_BYTES(4), .OUTPUT_BYTES(2), .PIPELINE_STAGES(1), .CNT_BITS(32)
    ) u_dut_w42 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .axis_s_data_i(w42_s_data), .axis_s_valid_i(w42_s_valid), .axis_s_ready_o(w42_s_ready),
        .axis_s_last_i(w42_s_last),
        .axis_m_data_o(w42_m_data), .axis_m_valid_o(w42_m_valid), .axis_m_ready_i(w_m_ready),
        .axis_m_last_o(w42_m_last)
`ifdef AXIS_PIPE_STATS_EN
        , .beat_cnt_o(unused_w42_beat), .frame_cnt_o(unused_w42_frame)
`endif
    );

    axis_pipe_slice_chain #(
        .INPUT_BYTES(2), .OUTPUT_BYTES(4), .PIPELINE_STAGES(1), .CNT_BITS(32)
    ) u_dut_w24 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .axis_s_data_i(w24_s_data), .axis_s_valid_i(w24_s_valid), .axis_s_ready_o(w24_s_ready),
        .axis_s_last_i(w24_s_last),
        .axis_m_data_o(w24_m_data), .axis_m_valid_o(w24_m_valid), .axis_m_ready_i(w_m_ready),
        .axis_m_last_o(w24_m_last)
`ifdef AXIS_PIPE_STATS_EN
        , .beat_cnt_o(unused_w24_beat), .frame_cnt_o(unused_w24_frame)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic [32:0] sb[$];
    int  cyc = 0;
    int  in_fire_cnt, out_fire_cnt, rdy_low_cnt, mvalid_cnt;
    int  first_in_cyc, first_out_cyc, last_out_cyc;
    bit  in_fired;
    bit  stall_prev = 1'b0;

    task automatic clr_stats();
        in_fire_cnt   = 0;
        out_fire_cnt  = 0;
        rdy_low_cnt   = 0;
        mvalid_cnt    = 0;
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
    endtask

    // Sample at the falling edge, then return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk_i);
        cyc++;
        in_fired = 1'b0;
        if (!s_ready) rdy_low_cnt++;
        if (stall_prev) chk("hold_valid", 64'(m_valid), 64'd1);
        if (s_valid && s_ready) begin
            sb.push_back({s_last, s_data});
            in_fired = 1'b1;
            in_fire_cnt++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        if (m_valid) begin
            mvalid_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'd1, 64'd0);
            end else begin
                chk("m_beat", 64'({m_last, m_data}), 64'(sb[0]));
                if (m_ready) begin
                    void'(sb.pop_front());
                    out_fire_cnt++;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                end
            end
        end
        stall_prev = m_valid && !m_ready;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            tick();
            n++;
        end while (!in_fired && n < 200);
        if (!in_fired) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rstn_i  = 1'b0;
        s_valid = 1'b0;
        sb.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int idx;
        int n;

        rstn_i      = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        m_ready     = 1'b0;
        w42_s_valid = 1'b0; w42_s_data = '0; w42_s_last = 1'b0;
        w24_s_valid = 1'b0; w24_s_data = '0; w24_s_last = 1'b0;
        clr_stats();

        // Reset and idle
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
`ifdef AXIS_PIPE_STATS_EN
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        tick();
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Streaming 16 beats with the sink always ready
        clr_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(32'(i), (i == 15));
        repeat (6) tick();
        chk("stream_latency", 64'(first_out_cyc - first_in_cyc), 64'd2);
        chk("stream_out_cnt", 64'(out_fire_cnt), 64'd16);
        chk("stream_back_to_back", 64'(last_out_cyc - first_out_cyc), 64'd15);
        chk("stream_ready_drops", 64'(rdy_low_cnt), 64'd0);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Full backpressure: offer 6 beats, 4 fit
        clr_stats();
        m_ready = 1'b0;
        acc     = 0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        repeat (10) begin
            s_data = 32'h100 + 32'(acc);
            tick();
            if (in_fired) acc++;
            if (acc == 6) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_s_ready", 64'(s_ready), 64'd0);
        chk("bp_m_valid", 64'(m_valid), 64'd1);
        repeat (5) tick();
        chk("bp_stall_data", 64'(m_data), 64'h100);
        m_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drain_cnt", 64'(out_fire_cnt), 64'd4);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_ready_back", 64'(s_ready), 64'd1);

        // Random valid/ready, 1000 beats, last on every 64th
        reset_pulse();
`ifdef AXIS_PIPE_STATS_EN
        chk("rand_rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
        clr_stats();
        idx = 0;
        n   = 0;
        while ((idx < 1000 || sb.size() != 0) && n < 20000) begin
            if (!s_valid && idx < 1000 && $urandom_range(1, 0) == 1) begin
                s_valid = 1'b1;
                s_data  = 32'(idx);
                s_last  = (idx % 64 == 63);
            end
            m_ready = ($urandom_range(1, 0) == 1);
            tick();
            n++;
            if (in_fired) begin
                idx++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("rand_no_timeout", 64'(n < 20000), 64'd1);
        chk("rand_in_cnt", 64'(in_fire_cnt), 64'd1000);
        chk("rand_out_cnt", 64'(out_fire_cnt), 64'd1000);
`ifdef AXIS_PIPE_STATS_EN
        chk("rand_beat_cnt", 64'(beat_cnt), 64'd1000);
        chk("rand_frame_cnt", 64'(frame_cnt), 64'd15);
`endif

        // Width adaptation, single-stage instances
        w42_s_valid = 1'b1; w42_s_data = 32'hDEADBEEF; w42_s_last = 1'b1;
        w24_s_valid = 1'b1; w24_s_data = 16'h1234;     w24_s_last = 1'b0;
        @(negedge clk_i);
        chk("w42_s_ready", 64'(w42_s_ready), 64'd1);
        chk("w24_s_ready", 64'(w24_s_ready), 64'd1);
        @(posedge clk_i);
        #1;
        w42_s_valid = 1'b0;
        w24_s_valid = 1'b0;
        @(negedge clk_i);
        chk("w42_m_valid", 64'(w42_m_valid), 64'd1);
        chk("w42_m_data", 64'(w42_m_data), 64'hBEEF);
        chk("w42_m_last", 64'(w42_m_last), 64'd1);
        chk("w24_m_valid", 64'(w24_m_valid), 64'd1);
        chk("w24_m_data", 64'(w24_m_data), 64'h0000_1234);
        chk("w24_m_last", 64'(w24_m_last), 64'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("w42_drained", 64'(w42_m_valid), 64'd0);
        chk("w24_drained", 64'(w24_m_valid), 64'd0);
        @(posedge clk_i);
        #1;

        // Reset with three beats buffered
        clr_stats();
        m_ready = 1'b0;
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b1);
        chk("mid_m_valid_before", 64'(m_valid), 64'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("mid_m_valid_async", 64'(m_valid), 64'd0);
        chk("mid_s_ready_async", 64'(s_ready), 64'd1);
        reset_pulse();
        clr_stats();
        m_ready = 1'b1;
        repeat (8) tick();
        chk("mid_no_stale_valid", 64'(mvalid_cnt), 64'd0);
        chk("mid_no_stale_fire", 64'(out_fire_cnt), 64'd0);
`ifdef AXIS_PIPE_STATS_EN
        chk("mid_beat_cnt", 64'(beat_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
